// File: rtl/tdm_scan_mux_pkg.sv
// Shared types for the TDM scan multiplexer: mode encoding and control FSM states.
package tdm_scan_mux_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'd0,
    MODE_SCAN   = 2'd1,
    MODE_MASKED = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/rr_next_ch.sv
// Circular priority search: first set mask bit at or after ptr, wrapping modulo NCH.
module rr_next_ch #(
  parameter int SEL_W = 4,
  parameter int NCH   = 2**SEL_W
) (
  input  logic [SEL_W-1:0] ptr,
  input  logic [NCH-1:0]   mask,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  logic [SEL_W-1:0] c;

  // Walk from the farthest offset down so the nearest hit is the last to write.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    c     = '0;
    for (int i = NCH-1; i >= 0; i--) begin
      c = ptr + i[SEL_W-1:0];
      if (mask[c]) begin
        idx   = c;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdm_scan_mux.sv
// Time-division channel multiplexer with manual, sequential and masked scan modes
// feeding a single-entry valid/ready output register.
module tdm_scan_mux
  import tdm_scan_mux_pkg::*;
#(
  parameter int SEL_W  = 4,
  parameter int DATA_W = 8,
  localparam int NCH   = 2**SEL_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH*DATA_W-1:0] in,
  input  logic [NCH-1:0]        ch_en,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      sel_in,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [SEL_W-1:0]      out_ch,
  output logic                  scan_wrap
);

  state_e           state, state_nxt;
  mode_e            md;
  logic [SEL_W-1:0] ptr;
  logic [NCH-1:0]   mask;
  logic [SEL_W-1:0] rr_idx, ld_ch;
  logic             rr_found, slot_free, load;

  assign md        = mode_e'(mode);
  assign mask      = (md == MODE_MASKED) ? ch_en : '1;
  assign slot_free = !out_valid || out_ready;
  assign ld_ch     = (md == MODE_MANUAL) ? sel_in : rr_idx;
  assign load      = (state == ST_RUN) && slot_free && (md != MODE_HOLD) &&
                     ((md == MODE_MANUAL) || rr_found);

  rr_next_ch #(.SEL_W(SEL_W), .NCH(NCH)) u_rr (
    .ptr   (ptr),
    .mask  (mask),
    .idx   (rr_idx),
    .found (rr_found)
  );

  // stop has priority over start in every state
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (!stop && start) state_nxt = ST_RUN;
      ST_RUN:   if (stop) state_nxt = ST_DRAIN;
      ST_DRAIN: if (slot_free) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      scan_wrap <= 1'b0;
    end else if (slot_free) begin
      out_valid <= load;
      if (load) begin
        ptr       <= ld_ch + 1'b1;
        out_data  <= in[ld_ch*DATA_W +: DATA_W];
        out_ch    <= ld_ch;
        scan_wrap <= (md != MODE_MANUAL) && (ld_ch == SEL_W'(NCH-1));
      end
    end
  end

endmodule

// File: tb/tb_tdm_scan_mux.sv
// Directed bench for tdm_scan_mux at SEL_W=4, DATA_W=8, channel k carrying 8'h10+k.
module tb_tdm_scan_mux;
  import tdm_scan_mux_pkg::*;

  localparam int SEL_W = 4, DATA_W = 8, NCH = 16;

  logic                  clk = 1'b0, rst_n = 1'b0;
  logic [NCH*DATA_W-1:0] in;
  logic [NCH-1:0]        ch_en = '0;
  logic [1:0]            mode = 2'd0;
  logic [SEL_W-1:0]      sel_in = '0;
  logic                  start = 1'b0, stop = 1'b0, out_ready = 1'b0;
  logic                  out_valid, scan_wrap;
  logic [DATA_W-1:0]     out_data;
  logic [SEL_W-1:0]      out_ch;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  tdm_scan_mux #(.SEL_W(SEL_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .ch_en(ch_en), .mode(mode), .sel_in(sel_in),
    .start(start), .stop(stop), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ch(out_ch), .scan_wrap(scan_wrap)
  );

  initial for (int k = 0; k < NCH; k++) in[k*DATA_W +: DATA_W] = 8'h10 + k[7:0];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    start = 0; stop = 0; out_ready = 0; ch_en = '0; mode = 2'd0; sel_in = '0;
    rst_n = 0; #3; rst_n = 1;
    step();
  endtask

  task automatic pulse_start();
    start = 1; step(); start = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; #2;
    checks++;
    if ({out_valid, out_data, out_ch, scan_wrap} !== 14'd0) begin
      errors++; $display("FAIL reset_outs got %h want 0", {out_valid, out_data, out_ch, scan_wrap});
    end
    rst_n = 1; out_ready = 1; mode = 2'd1;
    for (int i = 0; i < 3; i++) begin
      step(); checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_nostart got %b want 0", out_valid); end
    end
  endtask

  task automatic test_manual();
    do_reset(); mode = 2'd0; sel_in = 4'hD; out_ready = 1;
    pulse_start();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL manual_lat got %b want 0", out_valid); end
    for (int i = 0; i < 4; i++) begin
      step(); checks++;
      if ({out_valid, out_data, out_ch, scan_wrap} !== {1'b1, 8'h1D, 4'hD, 1'b0}) begin
        errors++; $display("FAIL manual_beat%0d got v=%b d=%h ch=%h w=%b want v=1 d=1d ch=d w=0",
                           i, out_valid, out_data, out_ch, scan_wrap);
      end
    end
  endtask

  task automatic test_scan();
    logic [3:0] e;
    do_reset(); mode = 2'd1; out_ready = 1;
    pulse_start();
    for (int i = 0; i < 18; i++) begin
      step(); e = 4'(i % 16); checks++;
      if ({out_valid, out_data, out_ch, scan_wrap} !== {1'b1, 8'h10 + {4'h0, e}, e, e == 4'hF}) begin
        errors++; $display("FAIL scan_beat%0d got v=%b d=%h ch=%h w=%b want ch=%h", i,
                           out_valid, out_data, out_ch, scan_wrap, e);
      end
    end
  endtask

  task automatic test_masked();
    logic [3:0] exp_ch [5];
    exp_ch = '{4'd0, 4'd2, 4'd15, 4'd0, 4'd2};
    do_reset(); mode = 2'd2; ch_en = 16'h8005; out_ready = 1;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      step(); checks++;
      if ({out_valid, out_ch, scan_wrap} !== {1'b1, exp_ch[i], exp_ch[i] == 4'hF}) begin
        errors++; $display("FAIL masked_beat%0d got v=%b ch=%h w=%b want ch=%h", i,
                           out_valid, out_ch, scan_wrap, exp_ch[i]);
      end
    end
    ch_en = '0;
    for (int i = 0; i < 3; i++) begin
      step(); checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL masked_empty%0d got %b want 0", i, out_valid); end
    end
    ch_en = '1; step(); checks++;
    if ({out_valid, out_ch} !== {1'b1, 4'd3}) begin
      errors++; $display("FAIL masked_ptrhold got v=%b ch=%h want v=1 ch=3", out_valid, out_ch);
    end
  endtask

  task automatic test_backpressure();
    do_reset(); mode = 2'd1; out_ready = 1;
    pulse_start();
    for (int i = 0; i < 4; i++) step();
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step(); checks++;
      if ({out_valid, out_data, out_ch, scan_wrap} !== {1'b1, 8'h13, 4'd3, 1'b0}) begin
        errors++; $display("FAIL bp_stable%0d got v=%b d=%h ch=%h want v=1 d=13 ch=3", i,
                           out_valid, out_data, out_ch);
      end
    end
    out_ready = 1;
    for (int i = 4; i < 6; i++) begin
      step(); checks++;
      if ({out_valid, out_ch} !== {1'b1, 4'(i)}) begin
        errors++; $display("FAIL bp_next got ch=%h want %h", out_ch, 4'(i));
      end
    end
  endtask

  task automatic test_drain();
    do_reset(); mode = 2'd1; out_ready = 1;
    pulse_start();
    step();
    out_ready = 0; stop = 1; step(); stop = 0;
    step(); checks++;
    if ({out_valid, out_ch} !== {1'b1, 4'd0} || dut.state !== ST_DRAIN) begin
      errors++; $display("FAIL drain_hold got v=%b ch=%h st=%0d want v=1 ch=0 st=2",
                         out_valid, out_ch, dut.state);
    end
    out_ready = 1; step(); checks++;
    if (out_valid !== 1'b0 || dut.state !== ST_IDLE) begin
      errors++; $display("FAIL drain_done got v=%b st=%0d want v=0 st=0", out_valid, dut.state);
    end
    start = 1; stop = 1; step(); start = 0; stop = 0;
    for (int i = 0; i < 3; i++) begin
      step(); checks++;
      if (out_valid !== 1'b0 || dut.state !== ST_IDLE) begin
        errors++; $display("FAIL startstop got v=%b st=%0d want v=0 st=0", out_valid, dut.state);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset(); mode = 2'd1; out_ready = 1;
    pulse_start();
    for (int i = 0; i < 6; i++) step();
    rst_n = 0; #1; checks++;
    if ({out_valid, out_data, out_ch, scan_wrap} !== 14'd0) begin
      errors++; $display("FAIL midreset got %h want 0", {out_valid, out_data, out_ch, scan_wrap});
    end
    step(); rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      step(); checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_idle%0d got %b want 0", i, out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_scan();
    test_masked();
    test_backpressure();
    test_drain();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/tdm_scan_mux.md
TDM_SCAN_MUX -- requirements
Module: tdm_scan_mux

Interface
REQ-001 The block SHALL have parameter SEL_W, default 4, meaning select width; channel count NCH = 2**SEL_W.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning width of each channel.
REQ-003 The block SHALL have a single clock and an asynchronous, active-low reset; ports follow.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in  input  NCH*DATA_W  flattened channels; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-007 ch_en  input  NCH  per-channel enable mask; used only in SCAN_MASKED mode.
REQ-008 mode  input  2  0=MANUAL, 1=SCAN, 2=SCAN_MASKED, 3=HOLD.
REQ-009 sel_in  input  SEL_W  channel select in MANUAL mode.
REQ-010 start  input  1  single-cycle pulse; begins operation.
REQ-011 stop  input  1  single-cycle pulse; ends operation after drain.
REQ-012 out_ready  input  1  downstream accepts the current beat.
REQ-013 out_valid  output  1  out_data/out_ch hold a beat.
REQ-014 out_data  output  DATA_W  registered selected channel data.
REQ-015 out_ch  output  SEL_W  index of the channel in out_data.
REQ-016 scan_wrap  output  1  high with any beat whose out_ch = NCH-1 in SCAN or SCAN_MASKED mode.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-018 The FSM SHALL transition IDLE->RUN on start, RUN->DRAIN on stop, and DRAIN->IDLE in the cycle where out_valid=0 or out_ready=1.
REQ-019 When start and stop are both high, stop SHALL win: IDLE stays IDLE and RUN goes to DRAIN.
REQ-020 The slot-free condition SHALL be !out_valid || out_ready; a load SHALL occur only in RUN with slot free and mode != HOLD.
REQ-021 Load latency SHALL be one cycle: the registers update on the edge that samples the load condition.
REQ-022 MANUAL SHALL load channel sel_in and set ptr = sel_in+1 (mod NCH).
REQ-023 SCAN SHALL load channel ptr, then ptr = ptr+1, wrapping from NCH-1 to 0.
REQ-024 SCAN_MASKED SHALL load the first enabled channel at or after ptr (circular search), then set ptr to that channel+1 (mod NCH).
REQ-025 In SCAN_MASKED with ch_en = 0, no load SHALL occur and ptr SHALL be unchanged.
REQ-026 HOLD SHALL load nothing; an existing beat is kept until it is accepted.
REQ-027 When a slot is free but no load occurs, out_valid SHALL go to 0 on the next edge.
REQ-028 While out_valid=1 and out_ready=0, out_data, out_ch and scan_wrap SHALL be stable and ptr SHALL not advance.
REQ-029 A mode or sel_in change SHALL take effect at the next load; ptr SHALL never be reset by a mode change.
REQ-030 IDLE and DRAIN SHALL never load.

Reset
REQ-031 While rst_n=0, the FSM SHALL be IDLE, ptr = 0, and out_valid, out_data, out_ch and scan_wrap SHALL all be 0, taking effect immediately and asynchronously.
REQ-032 After reset release, no beat SHALL appear until a start pulse is received.
REQ-033 Reset mid-run SHALL discard any pending beat.

Structure
REQ-034 The mode encoding and the FSM state enum SHALL live in a shared package tdm_scan_mux_pkg.
REQ-035 The masked circular next-channel search SHALL be a sub-module rr_next_ch (inputs ptr and mask; outputs index and found); SCAN uses it with an all-ones mask.
REQ-036 The implementation SHALL work for SEL_W 1..6 and DATA_W 1..32.

Verification (SEL_W=4, DATA_W=8, channel k = 8'h10+k)
REQ-037 MANUAL, sel_in=4'hD, start, ready=1 -> from the 2nd edge after start, out_data=8'h1D and out_ch=4'hD every cycle; scan_wrap=0.
REQ-038 SCAN, ready=1 -> out_ch 0,1,...,15,0,1; scan_wrap=1 only on the out_ch=15 beats; out_data = 8'h10+out_ch.
REQ-039 SCAN_MASKED, ch_en=16'h8005 -> out_ch 0,2,15,0,2; changing to ch_en=0 -> out_valid drops after the beat is accepted and ptr holds.
REQ-040 SCAN with ready=0 for 5 cycles at out_ch=3 -> outputs stable for all 5 cycles; the next beat after ready=1 is out_ch=4 (no skip).
REQ-041 stop while ready=0 -> DRAIN holds the beat; on ready=1 out_valid=0 and the FSM is IDLE; a simultaneous start+stop in IDLE has no effect.
REQ-042 rst_n low mid-SCAN -> outputs 0 in the same cycle; after release with no start, out_valid stays 0 for 10 cycles.
